// File: rtl/opacity_mask_bank_pkg.sv
// Shared constants and types for the double-buffered per-object opacity mask store.
package opacity_mask_bank_pkg;

    localparam int IMAGE_SIZE   = 32;
    localparam int MASK_NUM_OBJ = 2;

    typedef enum logic {
        CLR_IDLE,
        CLR_CLEAR
    } clear_state_e;

    // Car ids start at 1 in the game logic; mask planes are indexed from 0.
    function automatic int mask_obj_index(input int obj_id);
        return (obj_id > 0) ? obj_id - 1 : 0;
    endfunction

endpackage

// File: rtl/opacity_mask_plane.sv
// One IMG_SIZE x IMG_SIZE opacity bit plane with a write port, a whole-row clear
// port and a registered read port. Out-of-range accesses write nothing and read 0.
module opacity_mask_plane #(
    parameter int IMG_SIZE = 32,
    parameter int COOR_W   = $clog2(IMG_SIZE)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [COOR_W-1:0] i_wr_row,
    input  logic [COOR_W-1:0] i_wr_col,
    input  logic              i_wr_bit,
    input  logic              i_clr_en,
    input  logic [COOR_W-1:0] i_clr_row,
    input  logic [COOR_W-1:0] i_rd_row,
    input  logic [COOR_W-1:0] i_rd_col,
    output logic              o_rd_bit
);

    localparam logic [COOR_W:0] EDGE_LEN = (COOR_W+1)'(IMG_SIZE);

    logic [IMG_SIZE-1:0] mem_q [IMG_SIZE];
    logic                wr_in_range;
    logic                rd_in_range;

    assign wr_in_range = ({1'b0, i_wr_row} < EDGE_LEN) && ({1'b0, i_wr_col} < EDGE_LEN);
    assign rd_in_range = ({1'b0, i_rd_row} < EDGE_LEN) && ({1'b0, i_rd_col} < EDGE_LEN);

    // Row clear wins over a write; the bank controller never issues both at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q <= '{default: '0};
        end else if (i_clr_en) begin
            mem_q[i_clr_row] <= '0;
        end else if (i_wr_en && wr_in_range) begin
            mem_q[i_wr_row][i_wr_col] <= i_wr_bit;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_bit <= 1'b0;
        end else begin
            o_rd_bit <= rd_in_range ? mem_q[i_rd_row][i_rd_col] : 1'b0;
        end
    end

endmodule

// File: rtl/opacity_mask_bank.sv
// Double-buffered opacity mask store: encoder writes the back bank, decoder reads the
// front bank, frame_done swaps them and the new back bank is optionally cleared row by row.
module opacity_mask_bank
    import opacity_mask_bank_pkg::*;
#(
    parameter int NUM_OBJ       = MASK_NUM_OBJ,
    parameter int IMG_SIZE      = IMAGE_SIZE,
    parameter int COOR_W        = $clog2(IMG_SIZE),
    parameter int OBJ_W         = ($clog2(NUM_OBJ) > 0) ? $clog2(NUM_OBJ) : 1,
    parameter bit CLEAR_ON_SWAP = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [OBJ_W-1:0]          i_wr_obj,
    input  logic [COOR_W-1:0]         i_wr_row,
    input  logic [COOR_W-1:0]         i_wr_col,
    input  logic                      i_wr_opacity,
    input  logic                      i_frame_done,
    input  logic [NUM_OBJ*COOR_W-1:0] i_rd_row,
    input  logic [NUM_OBJ*COOR_W-1:0] i_rd_col,
    output logic [NUM_OBJ-1:0]        o_rd_opacity,
    output logic                      o_front_sel,
    output logic                      o_clear_busy,
    output logic                      o_overrun
);

    localparam logic [COOR_W:0] LAST_ROW = (COOR_W+1)'(IMG_SIZE - 1);
    localparam logic [COOR_W:0] CNT_MAX  = (COOR_W+1)'(IMG_SIZE);

    clear_state_e       state_q, state_d;
    logic [COOR_W:0]    row_cnt_q, row_cnt_d;
    logic               front_sel_q;
    logic               rd_sel_q;
    logic               overrun_q;
    logic               swap;
    logic               set_overrun;
    logic               clr_en;
    logic               wr_fire;
    logic [NUM_OBJ-1:0] rd_bits [2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= CLR_IDLE;
            row_cnt_q   <= '0;
            front_sel_q <= 1'b0;
            rd_sel_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            front_sel_q <= swap ? ~front_sel_q : front_sel_q;
            rd_sel_q    <= front_sel_q;
            overrun_q   <= overrun_q | set_overrun;
        end
    end

    // A swap is only honoured from IDLE; a frame_done while clearing is flagged instead.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        swap        = 1'b0;
        set_overrun = 1'b0;
        clr_en      = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (i_frame_done) begin
                    swap = 1'b1;
                    if (CLEAR_ON_SWAP) begin
                        state_d   = CLR_CLEAR;
                        row_cnt_d = '0;
                    end
                end
            end
            CLR_CLEAR: begin
                clr_en      = 1'b1;
                set_overrun = i_frame_done;
                if (row_cnt_q < CNT_MAX) begin
                    row_cnt_d = row_cnt_q + (COOR_W+1)'(1);
                end
                if (row_cnt_q >= LAST_ROW) begin
                    state_d = CLR_IDLE;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign o_wr_ready   = (state_q == CLR_IDLE);
    assign o_clear_busy = (state_q == CLR_CLEAR);
    assign o_front_sel  = front_sel_q;
    assign o_overrun    = overrun_q;
    assign wr_fire      = i_wr_valid && o_wr_ready;

    // Object indices with no matching plane simply enable nothing.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_back;
        assign is_back = (front_sel_q != 1'(b));
        for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
            opacity_mask_plane #(
                .IMG_SIZE (IMG_SIZE),
                .COOR_W   (COOR_W)
            ) u_plane (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_wr_en   (wr_fire && is_back && (i_wr_obj == OBJ_W'(k))),
                .i_wr_row  (i_wr_row),
                .i_wr_col  (i_wr_col),
                .i_wr_bit  (i_wr_opacity),
                .i_clr_en  (clr_en && is_back),
                .i_clr_row (row_cnt_q[COOR_W-1:0]),
                .i_rd_row  (i_rd_row[k*COOR_W +: COOR_W]),
                .i_rd_col  (i_rd_col[k*COOR_W +: COOR_W]),
                .o_rd_bit  (rd_bits[b][k])
            );
        end
    end

    // Both banks are read every cycle; rd_sel_q is the front index at read time.
    assign o_rd_opacity = rd_sel_q ? rd_bits[1] : rd_bits[0];

endmodule

// File: tb/tb_opacity_mask_bank.sv
// Self-checking bench for opacity_mask_bank: directed vectors, swap/clear sequences,
// a second configuration without clear-on-swap, and randomized traffic against a model.
module tb_opacity_mask_bank;

    localparam int NUM_OBJ    = 2;
    localparam int IMG_SIZE   = 32;
    localparam int COOR_W     = 5;
    localparam int OBJ_W      = 1;
    localparam int B_NUM_OBJ  = 3;
    localparam int B_IMG_SIZE = 20;
    localparam int B_COOR_W   = 5;
    localparam int B_OBJ_W    = 2;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;

    logic                      i_wr_valid, o_wr_ready, i_wr_opacity, i_frame_done;
    logic [OBJ_W-1:0]          i_wr_obj;
    logic [COOR_W-1:0]         i_wr_row, i_wr_col;
    logic [NUM_OBJ*COOR_W-1:0] i_rd_row, i_rd_col;
    logic [NUM_OBJ-1:0]        o_rd_opacity;
    logic                      o_front_sel, o_clear_busy, o_overrun;

    logic                          b_wr_valid, b_wr_ready, b_wr_opacity, b_frame_done;
    logic [B_OBJ_W-1:0]            b_wr_obj;
    logic [B_COOR_W-1:0]           b_wr_row, b_wr_col;
    logic [B_NUM_OBJ*B_COOR_W-1:0] b_rd_row, b_rd_col;
    logic [B_NUM_OBJ-1:0]          b_rd_opacity;
    logic                          b_front_sel, b_clear_busy, b_overrun;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    opacity_mask_bank #(
        .NUM_OBJ(NUM_OBJ), .IMG_SIZE(IMG_SIZE), .COOR_W(COOR_W), .OBJ_W(OBJ_W), .CLEAR_ON_SWAP(1'b1)
    ) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_obj(i_wr_obj),
        .i_wr_row(i_wr_row), .i_wr_col(i_wr_col), .i_wr_opacity(i_wr_opacity),
        .i_frame_done(i_frame_done), .i_rd_row(i_rd_row), .i_rd_col(i_rd_col),
        .o_rd_opacity(o_rd_opacity), .o_front_sel(o_front_sel),
        .o_clear_busy(o_clear_busy), .o_overrun(o_overrun)
    );

    opacity_mask_bank #(
        .NUM_OBJ(B_NUM_OBJ), .IMG_SIZE(B_IMG_SIZE), .COOR_W(B_COOR_W), .OBJ_W(B_OBJ_W), .CLEAR_ON_SWAP(1'b0)
    ) u_dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready), .i_wr_obj(b_wr_obj),
        .i_wr_row(b_wr_row), .i_wr_col(b_wr_col), .i_wr_opacity(b_wr_opacity),
        .i_frame_done(b_frame_done), .i_rd_row(b_rd_row), .i_rd_col(b_rd_col),
        .o_rd_opacity(b_rd_opacity), .o_front_sel(b_front_sel),
        .o_clear_busy(b_clear_busy), .o_overrun(b_overrun)
    );

    typedef struct {
        logic wv;
        int   obj, row, col;
        logic op;
        logic fd;
        int   rr, rc;
        int   e_rd, e_front, e_ready, e_busy;
    } vec_t;

    vec_t vecs[8];

    // Reference model: whole banks as arrays, clear modelled as instant at swap time
    // (the back bank is invisible and unwritable while the clear runs).
    bit mdl_bank [2][NUM_OBJ][IMG_SIZE][IMG_SIZE];
    int mdl_front;
    int mdl_busy;
    bit mdl_overrun;

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
    endtask

    task automatic setRead(input int row, input int col);
        i_rd_row = {NUM_OBJ{COOR_W'(row)}};
        i_rd_col = {NUM_OBJ{COOR_W'(col)}};
    endtask

    task automatic readAt(input string name, input int row, input int col, input int exp);
        setRead(row, col);
        applyStimulus();
        checkOutput(name, int'(o_rd_opacity), exp);
    endtask

    // Counts cycles spent clearing from the current state, with a write held pending.
    task automatic countBusy(input int fd_at, output int n);
        n = 0;
        i_wr_valid   = 1'b1;
        i_wr_obj     = '0;
        i_wr_row     = COOR_W'(3);
        i_wr_col     = COOR_W'(5);
        i_wr_opacity = 1'b1;
        for (int c = 0; c < 100 && o_clear_busy; c++) begin
            checkOutput("ready_low_in_clear", int'(o_wr_ready), 0);
            n++;
            i_frame_done = (c == fd_at);
            applyStimulus();
        end
        i_frame_done = 1'b0;
        i_wr_valid   = 1'b0;
    endtask

    task automatic swapAndCount(input int fd_at, output int n);
        i_frame_done = 1'b1;
        applyStimulus();
        i_frame_done = 1'b0;
        i_wr_valid   = 1'b0;
        countBusy(fd_at, n);
    endtask

    task automatic bWrite(input int obj, input int row, input int col);
        b_wr_valid   = 1'b1;
        b_wr_obj     = B_OBJ_W'(obj);
        b_wr_row     = B_COOR_W'(row);
        b_wr_col     = B_COOR_W'(col);
        b_wr_opacity = 1'b1;
        applyStimulus();
        b_wr_valid   = 1'b0;
        checkOutput("b_ready_on_write", int'(b_wr_ready), 1);
    endtask

    task automatic bReadAt(input string name, input int row, input int col, input int exp);
        b_rd_row = {B_NUM_OBJ{B_COOR_W'(row)}};
        b_rd_col = {B_NUM_OBJ{B_COOR_W'(col)}};
        applyStimulus();
        checkOutput(name, int'(b_rd_opacity), exp);
    endtask

    task automatic modelReset();
        foreach (mdl_bank[b, k, r, c]) mdl_bank[b][k][r][c] = 1'b0;
        mdl_front   = 0;
        mdl_busy    = 0;
        mdl_overrun = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int rr [NUM_OBJ];
        int rc [NUM_OBJ];
        int exp_rd;

        i_wr_valid = 0; i_wr_obj = '0; i_wr_row = '0; i_wr_col = '0; i_wr_opacity = 0;
        i_frame_done = 0; i_rd_row = '0; i_rd_col = '0;
        b_wr_valid = 0; b_wr_obj = '0; b_wr_row = '0; b_wr_col = '0; b_wr_opacity = 0;
        b_frame_done = 0; b_rd_row = '0; b_rd_col = '0;

        vecs[0] = '{1'b0, 0, 0, 0,  1'b0, 1'b0, 3, 5,  0, 0, 1, 0};
        vecs[1] = '{1'b1, 1, 7, 9,  1'b1, 1'b0, 7, 9,  0, 0, 1, 0};
        vecs[2] = '{1'b1, 0, 1, 1,  1'b1, 1'b0, 1, 1,  0, 0, 1, 0};
        vecs[3] = '{1'b1, 1, 2, 30, 1'b1, 1'b0, 2, 30, 0, 0, 1, 0};
        vecs[4] = '{1'b0, 0, 0, 0,  1'b0, 1'b1, 7, 9,  0, 1, 0, 1};
        vecs[5] = '{1'b0, 0, 0, 0,  1'b0, 1'b0, 7, 9,  2, 1, 0, 1};
        vecs[6] = '{1'b0, 0, 0, 0,  1'b0, 1'b0, 1, 1,  1, 1, 0, 1};
        vecs[7] = '{1'b1, 0, 3, 5,  1'b1, 1'b0, 2, 30, 2, 1, 0, 1};

        repeat (3) applyStimulus();
        i_rst_n = 1'b1;
        setRead(3, 5);
        applyStimulus();
        checkOutput("reset_rd", int'(o_rd_opacity), 0);
        checkOutput("reset_ready", int'(o_wr_ready), 1);
        checkOutput("reset_front", int'(o_front_sel), 0);
        checkOutput("reset_busy", int'(o_clear_busy), 0);
        checkOutput("reset_overrun", int'(o_overrun), 0);

        for (int i = 0; i < 8; i++) begin
            i_wr_valid   = vecs[i].wv;
            i_wr_obj     = OBJ_W'(vecs[i].obj);
            i_wr_row     = COOR_W'(vecs[i].row);
            i_wr_col     = COOR_W'(vecs[i].col);
            i_wr_opacity = vecs[i].op;
            i_frame_done = vecs[i].fd;
            setRead(vecs[i].rr, vecs[i].rc);
            applyStimulus();
            checkOutput($sformatf("vec%0d_rd", i), int'(o_rd_opacity), vecs[i].e_rd);
            checkOutput($sformatf("vec%0d_front", i), int'(o_front_sel), vecs[i].e_front);
            checkOutput($sformatf("vec%0d_ready", i), int'(o_wr_ready), vecs[i].e_ready);
            checkOutput($sformatf("vec%0d_busy", i), int'(o_clear_busy), vecs[i].e_busy);
        end

        // Rows 4..7 observed four clear cycles; countBusy re-counts the last one.
        countBusy(5, n);
        checkOutput("clear_len_first", n + 3, IMG_SIZE);
        checkOutput("front_after_ignored_fd", int'(o_front_sel), 1);
        checkOutput("overrun_set", int'(o_overrun), 1);
        readAt("swap1_obj1_7_9", 7, 9, 2);
        readAt("swap1_obj0_1_1", 1, 1, 1);
        readAt("swap1_obj1_2_30", 2, 30, 2);
        readAt("swap1_3_5", 3, 5, 0);

        i_wr_valid = 1'b1; i_wr_obj = '0; i_wr_row = '0; i_wr_col = '0; i_wr_opacity = 1'b1;
        swapAndCount(-1, n);
        checkOutput("clear_len_swap2", n, IMG_SIZE);
        checkOutput("front_swap2", int'(o_front_sel), 0);
        checkOutput("overrun_sticky", int'(o_overrun), 1);
        readAt("same_cycle_write_0_0", 0, 0, 1);
        readAt("dropped_write_3_5", 3, 5, 0);
        readAt("swap2_7_9", 7, 9, 0);

        swapAndCount(-1, n);
        checkOutput("clear_len_swap3", n, IMG_SIZE);
        checkOutput("front_swap3", int'(o_front_sel), 1);
        readAt("stale_cleared_7_9", 7, 9, 0);
        readAt("stale_cleared_1_1", 1, 1, 0);
        readAt("stale_cleared_2_30", 2, 30, 0);
        readAt("stale_cleared_3_5", 3, 5, 0);
        checkOutput("overrun_still_set", int'(o_overrun), 1);

        bWrite(3, 6, 6);
        bWrite(0, 20, 4);
        bWrite(0, 4, 20);
        bWrite(1, 4, 4);
        bWrite(2, 19, 19);
        b_frame_done = 1'b1;
        applyStimulus();
        b_frame_done = 1'b0;
        checkOutput("b_front_swap", int'(b_front_sel), 1);
        checkOutput("b_busy_no_clear", int'(b_clear_busy), 0);
        checkOutput("b_ready_no_clear", int'(b_wr_ready), 1);
        bReadAt("b_rd_4_4", 4, 4, 2);
        bReadAt("b_rd_19_19", 19, 19, 4);
        bReadAt("b_obj_oor_6_6", 6, 6, 0);
        bReadAt("b_row_oor", 20, 4, 0);
        bReadAt("b_col_oor", 4, 20, 0);
        b_frame_done = 1'b1;
        applyStimulus();
        checkOutput("b_front_back2back_1", int'(b_front_sel), 0);
        applyStimulus();
        b_frame_done = 1'b0;
        checkOutput("b_front_back2back_2", int'(b_front_sel), 1);
        checkOutput("b_overrun_clear", int'(b_overrun), 0);
        bReadAt("b_stale_kept_4_4", 4, 4, 2);

        i_rst_n = 1'b0;
        applyStimulus();
        i_rst_n = 1'b1;
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_wr_valid   = 1'($urandom_range(0, 1));
            i_wr_obj     = OBJ_W'($urandom_range(0, NUM_OBJ - 1));
            i_wr_row     = COOR_W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, IMG_SIZE - 1) : $urandom_range(0, 3));
            i_wr_col     = COOR_W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, IMG_SIZE - 1) : $urandom_range(0, 3));
            i_wr_opacity = 1'($urandom_range(0, 1));
            i_frame_done = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NUM_OBJ; k++) begin
                rr[k] = int'($urandom_range(0, 3));
                rc[k] = int'($urandom_range(0, 3));
                i_rd_row[k*COOR_W +: COOR_W] = COOR_W'(rr[k]);
                i_rd_col[k*COOR_W +: COOR_W] = COOR_W'(rc[k]);
            end

            exp_rd = 0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                if (mdl_bank[mdl_front][k][rr[k]][rc[k]]) exp_rd |= (1 << k);
            end
            if (i_wr_valid && mdl_busy == 0) begin
                mdl_bank[1 - mdl_front][int'(i_wr_obj)][int'(i_wr_row)][int'(i_wr_col)] = i_wr_opacity;
            end
            if (mdl_busy > 0) begin
                if (i_frame_done) mdl_overrun = 1'b1;
                mdl_busy--;
            end else if (i_frame_done) begin
                mdl_front = 1 - mdl_front;
                foreach (mdl_bank[0][k, r, c]) mdl_bank[1 - mdl_front][k][r][c] = 1'b0;
                mdl_busy = IMG_SIZE;
            end

            applyStimulus();
            checkOutput("rand_rd", int'(o_rd_opacity), exp_rd);
            checkOutput("rand_front", int'(o_front_sel), mdl_front);
            checkOutput("rand_busy", int'(o_clear_busy), (mdl_busy > 0) ? 1 : 0);
            checkOutput("rand_ready", int'(o_wr_ready), (mdl_busy == 0) ? 1 : 0);
            checkOutput("rand_overrun", int'(o_overrun), int'(mdl_overrun));
        end

        i_wr_valid = 1'b0;
        i_frame_done = 1'b0;
        for (int c = 0; c < 100 && o_clear_busy; c++) applyStimulus();
        checkOutput("idle_before_reset_test", int'(o_clear_busy), 0);
        i_frame_done = 1'b1;
        applyStimulus();
        i_frame_done = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("busy_mid_clear", int'(o_clear_busy), 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", int'(o_clear_busy), 0);
        checkOutput("midreset_ready", int'(o_wr_ready), 1);
        checkOutput("midreset_front", int'(o_front_sel), 0);
        checkOutput("midreset_overrun", int'(o_overrun), 0);
        checkOutput("midreset_rd", int'(o_rd_opacity), 0);
        applyStimulus();
        i_rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                readAt($sformatf("post_reset_zero_%0d_%0d", r, c), r, c, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
